// File: rtl/alarma_ctrl.sv
// Alarm sequencer: arming, exit/entry delays, timed siren bursts, disarm and panic around the A,B,C detector.
// Latency: one clock from any input to estado/cuenta/outputs; all outputs are registered.
// Backpressure: none; inputs are sampled every cycle and nothing is ever stalled.
module alarma_ctrl #(
    parameter int EXIT_CYC  = 8,
    parameter int ENTRY_CYC = 6,
    parameter int SIREN_CYC = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             disarm,
    input  logic             panic,
    input  logic             alarm_in,
    output logic [2:0]       estado,
    output logic [CNT_W-1:0] cuenta,
    output logic             armado,
    output logic             beep,
    output logic             sirena
);

    typedef enum logic [2:0] {
        DESARMADO = 3'd0,
        SALIDA    = 3'd1,
        ARMADO    = 3'd2,
        ENTRADA   = 3'd3,
        DISPARO   = 3'd4
    } estado_t;

    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYC - 1);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYC - 1);
    localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       nxt_estado;
    logic [CNT_W-1:0] nxt_cuenta;

    // Next state and timer: panic beats disarm, disarm beats everything else.
    always_comb begin
        nxt_estado = DESARMADO;
        nxt_cuenta = '0;
        if (panic) begin
            nxt_estado = DISPARO;
            nxt_cuenta = SIREN_LD;
        end else begin
            case (estado)
                DESARMADO: begin
                    // disarm together with arm keeps the panel disarmed
                    if (arm && !disarm) begin
                        nxt_estado = SALIDA;
                        nxt_cuenta = EXIT_LD;
                    end
                end
                SALIDA: begin
                    if (disarm) begin
                        nxt_estado = DESARMADO;
                    end else if (cuenta == '0) begin
                        nxt_estado = ARMADO;
                    end else begin
                        nxt_estado = SALIDA;
                        nxt_cuenta = cuenta - CNT_ONE;
                    end
                end
                ARMADO: begin
                    if (disarm) begin
                        nxt_estado = DESARMADO;
                    end else if (alarm_in) begin
                        nxt_estado = ENTRADA;
                        nxt_cuenta = ENTRY_LD;
                    end else begin
                        nxt_estado = ARMADO;
                    end
                end
                ENTRADA: begin
                    // detector dropping back low does not cancel the entry delay
                    if (disarm) begin
                        nxt_estado = DESARMADO;
                    end else if (cuenta == '0) begin
                        nxt_estado = DISPARO;
                        nxt_cuenta = SIREN_LD;
                    end else begin
                        nxt_estado = ENTRADA;
                        nxt_cuenta = cuenta - CNT_ONE;
                    end
                end
                DISPARO: begin
                    if (disarm) begin
                        nxt_estado = DESARMADO;
                    end else if (cuenta == '0) begin
                        // intrusion still present at end of burst retriggers the siren
                        if (alarm_in) begin
                            nxt_estado = DISPARO;
                            nxt_cuenta = SIREN_LD;
                        end else begin
                            nxt_estado = ARMADO;
                        end
                    end else begin
                        nxt_estado = DISPARO;
                        nxt_cuenta = cuenta - CNT_ONE;
                    end
                end
                default: begin
                    // unused codes fall back to a safe disarmed state
                    nxt_estado = DESARMADO;
                end
            endcase
        end
    end

    // State, timer and Moore outputs, registered together from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= DESARMADO;
            cuenta <= '0;
            armado <= 1'b0;
            beep   <= 1'b0;
            sirena <= 1'b0;
        end else begin
            estado <= nxt_estado;
            cuenta <= nxt_cuenta;
            armado <= (nxt_estado == ARMADO) || (nxt_estado == ENTRADA) || (nxt_estado == DISPARO);
            beep   <= (nxt_estado == SALIDA) || (nxt_estado == ENTRADA);
            sirena <= (nxt_estado == DISPARO);
        end
    end

endmodule

// File: tb/tb_alarma_ctrl.sv
// Directed bench for alarma_ctrl with hand-computed expected values.
// Latency: every check samples 1ns after the rising edge that should produce it.
// Backpressure: none; stimulus advances one clock per step.
module tb_alarma_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arm, disarm, panic, alarm_in;
    logic [2:0] estado;
    logic [4:0] cuenta;
    logic       armado, beep, sirena;

    int n_tests = 0;
    int n_fail  = 0;

    alarma_ctrl #(
        .EXIT_CYC (8),
        .ENTRY_CYC(6),
        .SIREN_CYC(16),
        .CNT_W    (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arm     (arm),
        .disarm  (disarm),
        .panic   (panic),
        .alarm_in(alarm_in),
        .estado  (estado),
        .cuenta  (cuenta),
        .armado  (armado),
        .beep    (beep),
        .sirena  (sirena)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int e_st, input int e_cnt,
                           input int e_arm, input int e_beep, input int e_sir);
        chk({tag, ".estado"}, int'(estado), e_st);
        chk({tag, ".cuenta"}, int'(cuenta), e_cnt);
        chk({tag, ".armado"}, int'(armado), e_arm);
        chk({tag, ".beep"},   int'(beep),   e_beep);
        chk({tag, ".sirena"}, int'(sirena), e_sir);
    endtask

    // From DESARMADO: arm pulse then full 8-cycle exit delay into ARMADO.
    task automatic go_armed();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk_all("arm_entry", 1, 7, 0, 1, 0);
        for (int i = 6; i >= 0; i--) begin
            tick();
            chk("exit_cnt", int'(cuenta), i);
            chk("exit_st", int'(estado), 1);
        end
        tick();
        chk_all("armed", 2, 0, 1, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; panic = 1'b0; alarm_in = 1'b0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_all("idle", 0, 0, 0, 0, 0);

        // alarm_in ignored while disarmed
        alarm_in = 1'b1;
        tick();
        alarm_in = 1'b0;
        chk_all("idle_alarm", 0, 0, 0, 0, 0);

        // exit delay
        go_armed();

        // arm ignored while armed
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk_all("armed_arm", 2, 0, 1, 0, 0);

        // one-cycle detection -> entry delay -> one siren burst -> back to armed
        alarm_in = 1'b1;
        tick();
        alarm_in = 1'b0;
        chk_all("entry", 3, 5, 1, 1, 0);
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk("entry_cnt", int'(cuenta), i);
            chk("entry_st", int'(estado), 3);
        end
        tick();
        chk_all("siren", 4, 15, 1, 0, 1);
        for (int i = 14; i >= 0; i--) begin
            tick();
            chk("siren_cnt", int'(cuenta), i);
            chk("siren_on", int'(sirena), 1);
        end
        tick();
        chk_all("siren_end", 2, 0, 1, 0, 0);

        // siren retrigger with alarm_in held, then disarm
        panic = 1'b1;
        tick();
        panic = 1'b0;
        alarm_in = 1'b1;
        chk_all("panic_armed", 4, 15, 1, 0, 1);
        for (int i = 14; i >= 0; i--) begin
            tick();
            chk("retrig_cnt", int'(cuenta), i);
            chk("retrig_sir", int'(sirena), 1);
        end
        tick();
        chk_all("retrig", 4, 15, 1, 0, 1);
        tick();
        chk_all("retrig_dec", 4, 14, 1, 0, 1);
        alarm_in = 1'b0;
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk_all("disarm_siren", 0, 0, 0, 0, 0);

        // disarm during entry at cuenta=3
        go_armed();
        alarm_in = 1'b1;
        tick();
        alarm_in = 1'b0;
        chk_all("entry2", 3, 5, 1, 1, 0);
        tick();
        tick();
        chk_all("entry2_3", 3, 3, 1, 1, 0);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk_all("disarm_entry", 0, 0, 0, 0, 0);
        tick();
        chk_all("after_disarm", 0, 0, 0, 0, 0);

        // panic beats disarm
        panic = 1'b1;
        disarm = 1'b1;
        tick();
        panic = 1'b0;
        disarm = 1'b0;
        chk_all("panic_prio", 4, 15, 1, 0, 1);

        // reset during siren at cuenta=9
        for (int i = 0; i < 6; i++) tick();
        chk_all("siren_9", 4, 9, 1, 0, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_all("mid_reset", 0, 0, 0, 0, 0);

        // arm and disarm together stay disarmed
        arm = 1'b1;
        disarm = 1'b1;
        tick();
        arm = 1'b0;
        disarm = 1'b0;
        chk_all("arm_disarm", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alarma_ctrl.md
Name: alarma_ctrl

Overview:
- Sequencing controller for the 3-input alarm logic (A,B,C -> Y); Y enters this block as `alarm_in`.
- Adds arming, exit delay, entry delay, timed siren, disarm and panic behaviour around that combinational detector.
- Single clock domain; sits between the panel inputs (buttons, code check) and the LEDs/siren driver.

Parameters:
- EXIT_CYC, 8, cycles spent in exit delay before the system becomes armed (≥1).
- ENTRY_CYC, 6, cycles of entry delay between detection and siren (≥1).
- SIREN_CYC, 16, cycles per siren burst (≥1).
- CNT_W, 5, counter width; must hold max(EXIT_CYC, ENTRY_CYC, SIREN_CYC)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- arm  in  1  arm request, sampled each cycle.
- disarm  in  1  valid-code strobe, sampled each cycle.
- panic  in  1  immediate alarm request.
- alarm_in  in  1  Y output of the alarm logic (1 = intrusion condition).
- estado  out  3  current state encoding.
- cuenta  out  CNT_W  remaining cycles of the active timer.
- armado  out  1  system armed indicator (LED).
- beep  out  1  delay indicator (exit/entry).
- sirena  out  1  siren drive.

Behaviour:
- One clock, clk; reset is synchronous and active-low (rst_n). On a rising clk edge with rst_n=0: estado=DESARMADO, cuenta=0, and all outputs are 0.
- State encoding:
  - DESARMADO=0
  - SALIDA=1
  - ARMADO=2
  - ENTRADA=3
  - DISPARO=4
  - Codes 5–7 recover to DESARMADO on the next edge.
- Moore machine: armado, beep and sirena are decoded from the registered estado only; no combinational path from inputs to outputs.
  - armado=1 in ARMADO, ENTRADA, DISPARO.
  - beep=1 in SALIDA, ENTRADA.
  - sirena=1 in DISPARO only.
- Input priority per cycle: panic > disarm > arm/alarm_in/timer expiry.
- panic=1 in any state -> DISPARO, cuenta loaded with SIREN_CYC-1.
- DESARMADO:
  - arm=1 -> SALIDA, cuenta=EXIT_CYC-1.
  - alarm_in is ignored.
  - disarm is a no-op.
- SALIDA:
  - disarm -> DESARMADO, cuenta=0.
  - Otherwise, if cuenta==0 -> ARMADO; else cuenta decrements by 1.
  - alarm_in and arm are ignored (occupant leaving).
- ARMADO:
  - disarm -> DESARMADO.
  - alarm_in=1 -> ENTRADA, cuenta=ENTRY_CYC-1.
  - arm is ignored.
- ENTRADA:
  - disarm -> DESARMADO.
  - Otherwise, if cuenta==0 -> DISPARO, cuenta=SIREN_CYC-1; else decrement.
  - alarm_in going low does NOT cancel the entry delay.
- DISPARO:
  - disarm -> DESARMADO.
  - When cuenta==0: if alarm_in=1, reload SIREN_CYC-1 and stay (retrigger); else -> ARMADO with cuenta=0.
  - Otherwise decrement.
- Latency and counter rules:
  - Time in SALIDA = EXIT_CYC cycles.
  - Time in ENTRADA = ENTRY_CYC cycles.
  - One siren burst = SIREN_CYC cycles.
  - cuenta never wraps: it is only decremented when nonzero, and only reloaded on state entry or retrigger.
  - cuenta=0 in DESARMADO and ARMADO.
- Reset mid-operation (including during DISPARO): sirena drops and estado=DESARMADO on the same edge; no timer state survives.
- Simultaneous arm+disarm in DESARMADO: disarm wins, so the state stays DESARMADO.

Test Plan:
- Reset then arm pulse at cycle 2 -> estado=1, beep=1, cuenta counts 7..0 over 8 cycles, then estado=2, armado=1, beep=0.
- Armed, alarm_in=1 (A,B,C combination giving Y=1) for 1 cycle -> ENTRADA for 6 cycles, cuenta 5..0, then DISPARO with sirena=1 for 16 cycles; alarm_in=0 at expiry -> ARMADO, sirena=0.
- DISPARO with alarm_in held 1 -> at cuenta==0 it reloads to 15 and sirena stays 1 continuously; disarm pulse -> DESARMADO next edge, sirena=0, armado=0.
- ENTRADA with disarm at cuenta=3 -> DESARMADO, cuenta=0, sirena never asserted.
- DESARMADO, panic=1 together with disarm=1 -> DISPARO, cuenta=15, sirena=1 (panic priority).
- rst_n=0 for one edge during DISPARO at cuenta=9 -> estado=0, cuenta=0, all outputs 0; arm+disarm same cycle afterwards -> stays DESARMADO.
